// File: rtl/onehot_sched_pkg.sv
// Shared definitions for the one-hot sequencer scheduler.
// Holds bit indices of the sequencer state vector, of the cmd vector and of
// a requester's route field, plus the scheduler phase encoding.
package onehot_sched_pkg;

    // Bit positions in the observed one-hot sequencer state
    localparam int S0 = 0;
    localparam int S1 = 1;
    localparam int S2 = 2;
    localparam int S3 = 3;
    localparam int S4 = 4;
    localparam int S5 = 5;

    // Bit positions in cmd
    localparam int CMD_GO = 0;
    localparam int CMD_A  = 1;
    localparam int CMD_X  = 2;

    // Bit positions in a requester's 2-bit route
    localparam int RT_A = 0;
    localparam int RT_X = 1;

    // IDLE: no grant; ARM: granted, waiting for S1; RUN: sequencer walking
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } phase_t;

endpackage

// File: rtl/onehot_sched_if.sv
// Bundle between the scheduler, its requesters and the shared sequencer.
//   req   : per-requester request
//   route : route[2i+1:2i] for requester i
//   state : one-hot state observed from the sequencer
//   cmd   : command to the sequencer
//   gnt   : one-hot grant (or zero)
//   done  : one-cycle completion pulse
//   busy  : a grant is active
//   err   : sticky error
// master drives requests and sequencer state; slave is the scheduler.
interface onehot_sched_if #(parameter int R = 4);
    logic [R-1:0]   req;
    logic [2*R-1:0] route;
    logic [5:0]     state;
    logic [2:0]     cmd;
    logic [R-1:0]   gnt;
    logic [R-1:0]   done;
    logic           busy;
    logic           err;

    modport master (output req, route, state, input cmd, gnt, done, busy, err);
    modport slave  (input req, route, state, output cmd, gnt, done, busy, err);
endinterface

// File: rtl/onehot_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : index with highest priority; search proceeds upward, wrapping
//   win : one-hot winner (zero when no request)
//   any : at least one request present
module rr_arbiter #(
    parameter int R = 4
) (
    input  logic [R-1:0]         req,
    input  logic [$clog2(R)-1:0] ptr,
    output logic [R-1:0]         win,
    output logic                 any
);

    int unsigned idx;
    logic        found;

    always_comb begin
        win   = '0;
        any   = |req;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < R; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= R) idx = idx - R;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_sched.sv
// Round-robin scheduler sharing a six-state one-hot sequencer between R
// requesters. Grants one requester, latches its route, steers the
// sequencer via cmd and pulses done when the sequencer returns to S0.
// A watchdog and a one-hot check on state raise a sticky err.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : onehot_sched_if slave (req/route/state in; cmd/gnt/done/busy/err out)
module onehot_sched
    import onehot_sched_pkg::*;
#(
    parameter int R   = 4,
    parameter int TMO = 8
) (
    input logic            clk,
    input logic            rst,
    onehot_sched_if.slave  bus
);

    localparam int PW = $clog2(R);
    localparam int WW = $clog2(TMO);

    phase_t          phase;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   win_idx;
    logic [R-1:0]    win;
    logic            any;
    logic [R-1:0]    gnt;
    logic [R-1:0]    done;
    logic [1:0]      rte;
    logic [1:0]      win_rte;
    logic [WW-1:0]   wdog;
    logic            err;
    logic            busy;
    logic [2:0]      cmd;

    rr_arbiter #(.R(R)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    // Winner index and its route, plus the pointer value that follows it
    always_comb begin
        win_idx = '0;
        win_rte = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
                win_rte = bus.route[2*i +: 2];
            end
        end
        ptr_next = (win_idx == PW'(R - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            done  <= '0;
            rte   <= '0;
            wdog  <= '0;
            err   <= 1'b0;
        end else begin
            done <= '0;
            if (!$onehot(bus.state)) err <= 1'b1;
            case (phase)
                IDLE: begin
                    if (any && !err && bus.state[S0]) begin
                        gnt   <= win;
                        rte   <= win_rte;
                        ptr   <= ptr_next;
                        wdog  <= '0;
                        phase <= ARM;
                    end
                end
                ARM, RUN: begin
                    // Completion beats the watchdog when both land on one edge
                    if (phase == RUN && bus.state[S0]) begin
                        phase <= IDLE;
                        gnt   <= '0;
                        done  <= gnt;
                    end else if (wdog == WW'(TMO - 1)) begin
                        phase <= IDLE;
                        gnt   <= '0;
                        err   <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (phase == ARM && bus.state[S1]) phase <= RUN;
                    end
                end
                default: phase <= IDLE;
            endcase
        end
    end

    assign busy = (phase != IDLE);

    // The route decode at S1 must already apply in ARM: the sequencer sits
    // in S1 during the cycle before started is registered.
    always_comb begin
        cmd = '0;
        if (busy && !err) begin
            if (bus.state[S0]) begin
                if (phase == ARM) cmd[CMD_GO] = 1'b1;
            end else if (bus.state[S1]) begin
                cmd[CMD_A]  = rte[RT_A];
                cmd[CMD_GO] = ~rte[RT_A];
            end else if (bus.state[S4]) begin
                cmd[CMD_X] = rte[RT_X];
            end
        end
    end

    assign bus.cmd  = cmd;
    assign bus.gnt  = gnt;
    assign bus.done = done;
    assign bus.busy = busy;
    assign bus.err  = err;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt));
    a_done_follows_gnt: assert property (@(posedge clk) disable iff (rst)
        (|done) |-> (done == $past(gnt)));
    a_cmd_idle_zero: assert property (@(posedge clk) disable iff (rst)
        !busy |-> (cmd == 3'b000));
    a_err_sticky: assert property (@(posedge clk) disable iff (rst)
        $past(err) |-> err);

endmodule

// File: tb/tb_onehot_sched.sv
module tb_onehot_sched;

    localparam int R   = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    onehot_sched_if #(.R(R)) bus ();

    onehot_sched #(.R(R), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int       ncmp = 0;
    int       nfail = 0;
    int       mptr = 0;
    bit       hold = 1'b0;
    bit       force_en = 1'b0;
    logic [5:0] force_val = 6'b000001;

    // Behaviour of the shared sequencer, from its transition rules
    function automatic logic [5:0] seq_next(input logic [5:0] s, input logic [2:0] c);
        if (s[0]) return c[0] ? 6'b000010 : 6'b000001;
        if (s[1]) return c[1] ? 6'b000100 : (c[0] ? 6'b001000 : 6'b000010);
        if (s[2] || s[3]) return 6'b010000;
        if (s[4]) return c[2] ? 6'b100000 : 6'b000001;
        return 6'b000001;
    endfunction

    // Round-robin reference: first requester at or above p, wrapping
    function automatic int pick(input int p, input logic [R-1:0] r);
        for (int k = 0; k < R; k++) begin
            int i;
            i = (p + k) % R;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // One clock: sequencer follows cmd of the current cycle; returns at negedge
    task automatic adv();
        logic [5:0] nxt;
        nxt = hold ? bus.state : seq_next(bus.state, bus.cmd);
        if (force_en) nxt = force_val;
        @(posedge clk);
        #1;
        bus.state = nxt;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        bus.state = 6'b000001;
        bus.req   = '0;
        bus.route = '0;
        hold      = 1'b0;
        force_en  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        mptr = 0;
    endtask

    // One full transaction from arbitration to done, with the sequencer obeying cmd
    task automatic run_txn(input logic [R-1:0] rq, input logic [2*R-1:0] rt,
                           input bit drop, input string name);
        int             w;
        int             len;
        logic [2*R-1:0] rtv;
        logic [1:0]     rb;
        logic [R-1:0]   eg;
        logic [2:0]     ecmd;
        bus.req   = rq;
        bus.route = rt;
        w   = pick(mptr, rq);
        eg  = '0;
        eg[w] = 1'b1;
        rtv = rt;
        rb  = rtv[2*w +: 2];
        len = rb[1] ? 5 : 4;
        adv();
        if (bus.gnt !== eg) begin nfail++; $display("FAIL %s gnt@G got %b want %b", name, bus.gnt, eg); end
        ncmp++;
        if (bus.cmd !== 3'b001 || bus.busy !== 1'b1 || bus.done !== '0) begin
            nfail++; $display("FAIL %s G cmd/busy/done got %b/%b/%b want 001/1/0", name, bus.cmd, bus.busy, bus.done);
        end
        ncmp++;
        mptr = (w + 1) % R;
        if (drop) begin
            bus.req   = R'($urandom);
            bus.route = (2*R)'($urandom);
        end
        for (int t = 1; t <= len + 1; t++) begin
            adv();
            ecmd = 3'b000;
            if (t == 1) ecmd = rb[0] ? 3'b010 : 3'b001;
            if (t == 3) ecmd = rb[1] ? 3'b100 : 3'b000;
            if (t <= len) begin
                if (bus.gnt !== eg || bus.done !== '0 || bus.cmd !== ecmd) begin
                    nfail++;
                    $display("FAIL %s G+%0d gnt/done/cmd got %b/%b/%b want %b/0000/%b",
                             name, t, bus.gnt, bus.done, bus.cmd, eg, ecmd);
                end
                ncmp++;
            end else begin
                if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.done !== eg || bus.cmd !== 3'b000) begin
                    nfail++;
                    $display("FAIL %s done@G+%0d gnt/busy/done/cmd got %b/%b/%b/%b want 0000/0/%b/000",
                             name, t, bus.gnt, bus.busy, bus.done, bus.cmd, eg);
                end
                ncmp++;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.state = 6'b000001;
        bus.req   = 4'b1111;
        bus.route = '0;
        #2;
        if (bus.gnt !== '0 || bus.done !== '0 || bus.busy !== 1'b0 ||
            bus.err !== 1'b0 || bus.cmd !== 3'b000) begin
            nfail++;
            $display("FAIL reset gnt/done/busy/err/cmd got %b/%b/%b/%b/%b want all 0",
                     bus.gnt, bus.done, bus.busy, bus.err, bus.cmd);
        end
        ncmp++;
        apply_reset();
    endtask

    task automatic test_single();
        run_txn(4'b0010, 8'b0000_0100, 1'b0, "single");
    endtask

    task automatic test_long();
        run_txn(4'b0001, 8'b0000_0010, 1'b0, "long");
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int n = 0; n < 5; n++) begin
            if (pick(mptr, 4'b1111) != order[n]) begin
                nfail++; $display("FAIL rr_model order n=%0d got %0d want %0d", n, pick(mptr, 4'b1111), order[n]);
            end
            run_txn(4'b1111, (2*R)'($urandom), 1'b0, "round_robin");
        end
    endtask

    task automatic test_random();
        logic [R-1:0] rq;
        for (int n = 0; n < 24; n++) begin
            rq = R'($urandom_range(1, (1 << R) - 1));
            run_txn(rq, (2*R)'($urandom), bit'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        hold      = 1'b1;
        bus.req   = 4'b0100;
        adv();
        if (bus.gnt !== 4'b0100 || bus.cmd !== 3'b001) begin
            nfail++; $display("FAIL wdog grant gnt/cmd got %b/%b want 0100/001", bus.gnt, bus.cmd);
        end
        ncmp++;
        bus.req = 4'b1111;
        for (int t = 1; t < TMO; t++) begin
            adv();
            if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.cmd !== 3'b001) begin
                nfail++;
                $display("FAIL wdog hold G+%0d gnt/busy/err/cmd got %b/%b/%b/%b want 0100/1/0/001",
                         t, bus.gnt, bus.busy, bus.err, bus.cmd);
            end
            ncmp++;
        end
        adv();
        if (bus.err !== 1'b1 || bus.gnt !== '0 || bus.busy !== 1'b0 || bus.done !== '0) begin
            nfail++;
            $display("FAIL wdog expiry err/gnt/busy/done got %b/%b/%b/%b want 1/0000/0/0000",
                     bus.err, bus.gnt, bus.busy, bus.done);
        end
        ncmp++;
        for (int t = 0; t < 10; t++) begin
            adv();
            if (bus.gnt !== '0 || bus.cmd !== 3'b000 || bus.err !== 1'b1) begin
                nfail++; $display("FAIL wdog after gnt/cmd/err got %b/%b/%b want 0000/000/1", bus.gnt, bus.cmd, bus.err);
            end
            ncmp++;
        end
        hold = 1'b0;
    endtask

    task automatic test_onehot_err();
        apply_reset();
        bus.req   = 4'b0001;
        bus.route = 8'b0000_0010;
        adv();
        adv();
        force_en  = 1'b1;
        force_val = 6'b000110;
        adv();
        if (bus.err !== 1'b0) begin
            nfail++; $display("FAIL onehot err early got %b want 0", bus.err);
        end
        ncmp++;
        force_val = 6'b010000;
        adv();
        if (bus.err !== 1'b1 || bus.cmd !== 3'b000) begin
            nfail++; $display("FAIL onehot next err/cmd got %b/%b want 1/000", bus.err, bus.cmd);
        end
        ncmp++;
        force_val = 6'b000001;
        adv();
        force_en = 1'b0;
        bus.req  = 4'b1111;
        repeat (5) adv();
        for (int t = 0; t < 12; t++) begin
            adv();
            if (bus.gnt !== '0 || bus.err !== 1'b1 || bus.cmd !== 3'b000) begin
                nfail++; $display("FAIL onehot after gnt/err/cmd got %b/%b/%b want 0000/1/000", bus.gnt, bus.err, bus.cmd);
            end
            ncmp++;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.req = 4'b0010;
        adv();
        if (bus.gnt !== 4'b0010) begin
            nfail++; $display("FAIL rstmid grant got %b want 0010", bus.gnt);
        end
        ncmp++;
        adv();
        adv();
        rst = 1'b1;
        #1;
        if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.done !== '0 || bus.cmd !== 3'b000 || bus.err !== 1'b0) begin
            nfail++;
            $display("FAIL rstmid async gnt/busy/done/cmd/err got %b/%b/%b/%b/%b want all 0",
                     bus.gnt, bus.busy, bus.done, bus.cmd, bus.err);
        end
        ncmp++;
        bus.state = 6'b000001;
        bus.req   = '0;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        mptr = 0;
        run_txn(4'b0110, 8'b0000_0000, 1'b0, "rstmid_ptr");
        run_txn(4'b1000, 8'b0000_0000, 1'b0, "rstmid_req3");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_long();
        test_round_robin();
        test_random();
        test_watchdog();
        test_onehot_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
